bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 11 +
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 tb/tb_bin2bcd_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int BCD_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Digits needed to show 2^w-1 without overflow: floor(w*log10(2)) + 1.
    function automatic int min_digits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock,
// with a start/ready/done handshake and a sticky overflow flag.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 10,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [W-1:0]              bin,
    output logic                      ready,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      ovf
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int SW = BCD_W * DIGITS;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [W-1:0]    shreg;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   scratch_adj;
    logic [SW-1:0]   scratch_next;
    logic            sticky;
    logic            sticky_next;
    logic            last_bit;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[i*BCD_W +: BCD_W]),
            .dout (scratch_adj[i*BCD_W +: BCD_W])
        );
    end

    // The bit leaving the top digit is a value that no longer fits in DIGITS.
    assign scratch_next = {scratch_adj[SW-2:0], shreg[W-1]};
    assign sticky_next  = sticky | scratch_adj[SW-1];
    assign last_bit     = (count == CW'(W - 1));
    assign ready        = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // bcd/ovf are only loaded on the final shift so downstream decoders never see partial results.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            shreg   <= '0;
            scratch <= '0;
            sticky  <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        sticky  <= 1'b0;
                        count   <= '0;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_next;
                    shreg   <= shreg << 1;
                    sticky  <= sticky_next;
                    count   <= count + 1'b1;
                    if (last_bit) begin
                        bcd  <= scratch_next;
                        ovf  <= sticky_next;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench: two converters (4 and 3 digits) share stimulus
// and are compared against a decimal reference model.
module tb_bin2bcd_seq;

    localparam int W = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [W-1:0] bin;
    logic        ready4, done4, ovf4;
    logic [15:0] bcd4;
    logic        ready3, done3, ovf3;
    logic [11:0] bcd3;

    int n_checks;
    int n_fail;

    logic [31:0] held4, held3;
    logic        hovf4, hovf3;

    bin2bcd_seq #(.W(W), .DIGITS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .ready (ready4),
        .done  (done4),
        .bcd   (bcd4),
        .ovf   (ovf4)
    );

    bin2bcd_seq #(.W(W), .DIGITS(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .ready (ready3),
        .done  (done3),
        .bcd   (bcd3),
        .ovf   (ovf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refBcd(input int value, input int digits);
        int v;
        logic [31:0] r;
        v = value;
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic refOvf(input int value, input int digits);
        int lim;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        return value > lim - 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            checkOutput("idle_done4", done4, 0);
            checkOutput("idle_ready4", ready4, 1);
            checkOutput("idle_bcd4", bcd4, held4);
            checkOutput("idle_bcd3", bcd3, held3);
            checkOutput("idle_ovf3", ovf3, hovf3);
        end
    endtask

    // Launches one conversion; poke_cycle >= 0 fires a stray start while busy.
    task automatic applyStimulus(input int value, input int poke_cycle);
        int cnt;
        bin   = W'(value);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = W'($urandom);
        cnt   = 0;
        while (!done4 && cnt < W + 4) begin
            checkOutput("busy_ready4", ready4, 0);
            checkOutput("busy_ready3", ready3, 0);
            checkOutput("busy_done3", done3, 0);
            checkOutput("busy_hold4", bcd4, held4);
            checkOutput("busy_hold3", bcd3, held3);
            checkOutput("busy_ovf4", ovf4, hovf4);
            checkOutput("busy_ovf3", ovf3, hovf3);
            if (cnt == poke_cycle) begin
                start = 1'b1;
                bin   = W'(7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        held4 = refBcd(value, 4);
        held3 = refBcd(value, 3);
        hovf4 = refOvf(value, 4);
        hovf3 = refOvf(value, 3);
        checkOutput("latency", cnt, W);
        checkOutput("done3", done3, 1);
        checkOutput("done_ready4", ready4, 1);
        checkOutput("bcd4", bcd4, held4);
        checkOutput("ovf4", ovf4, hovf4);
        checkOutput("bcd3", bcd3, held3);
        checkOutput("ovf3", ovf3, hovf3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        held4 = '0; held3 = '0; hovf4 = 1'b0; hovf3 = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_ready4", ready4, 1);
        checkOutput("rst_done4", done4, 0);
        checkOutput("rst_bcd4", bcd4, 0);
        checkOutput("rst_ovf4", ovf4, 0);
        checkOutput("rst_ready3", ready3, 1);
        checkOutput("rst_bcd3", bcd3, 0);
        idleCycles(2);

        applyStimulus(0, -1);
        idleCycles(1);
        applyStimulus(1023, -1);
        applyStimulus(999, -1);
        idleCycles(2);

        applyStimulus(512, 4);
        idleCycles(3);

        $display("[TB] reset during conversion");
        bin   = W'(345);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        held4 = '0; held3 = '0; hovf4 = 1'b0; hovf3 = 1'b0;
        checkOutput("abort_ready4", ready4, 1);
        checkOutput("abort_done4", done4, 0);
        checkOutput("abort_bcd4", bcd4, 0);
        checkOutput("abort_ovf4", ovf4, 0);
        idleCycles(W + 2);
        applyStimulus(345, -1);
        idleCycles(1);

        applyStimulus(1000, -1);
        idleCycles(1);
        applyStimulus(999, -1);
        idleCycles(1);

        $display("[TB] random sweep");
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 3)));
            applyStimulus(int'($urandom_range(0, 1023)), -1);
        end
        idleCycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
